// File: rtl/hazard_pkg.sv
// Shared definitions for the MIPS hazard/stall controller and its helpers.
// Holds the controller state encoding, the zero-register index and the
// default branch-resolution timeout.
package hazard_pkg;

    typedef enum logic [1:0] {
        HAZ_RUN     = 2'd0,
        HAZ_BR_WAIT = 2'd1,
        HAZ_FLUSH   = 2'd2
    } haz_state_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

    // Default number of cycles allowed in BR_WAIT before a forced release.
    localparam int BR_TIMEOUT_DEF = 8;

endpackage : hazard_pkg

// File: rtl/detecta_loaduse.sv
// Load-use hazard detector: flags an ID instruction reading the register a
// load in EX is about to write. Purely combinational, 0 latency, no flow control.
// Ports: IFID_rs/IFID_rt (ID sources), IDEX_rt/IDEX_memRead (EX load), lu (hazard).
module detecta_loaduse
    import hazard_pkg::*;
(
    input  logic [4:0] IFID_rs,
    input  logic [4:0] IFID_rt,
    input  logic [4:0] IDEX_rt,
    input  logic       IDEX_memRead,
    output logic       lu
);

    // $zero never carries a real dependency, so a load targeting it is harmless.
    assign lu = IDEX_memRead
              & (IDEX_rt != REG_ZERO)
              & ((IDEX_rt == IFID_rs) | (IDEX_rt == IFID_rt));

endmodule : detecta_loaduse

// File: rtl/controle_hazard_seq.sv
// Hazard/stall controller beside ID: load-use stalls, branch hold + flush,
// unified memory port arbitration and a saturating bubble counter.
// Stall outputs are combinational (0 latency); data access always wins the port.
// Ports: Clock/Reset, ID/EX hazard fields, branch status, PC/IFID enables,
// bubble mux, flush, MemSel, sticky ErroBranch, ContaBolhas counter.
module controle_hazard_seq
    import hazard_pkg::*;
#(
    parameter int BR_TIMEOUT = BR_TIMEOUT_DEF,
    parameter int CW         = 16
) (
    input  logic          Clock,
    input  logic          Reset,
    input  logic [4:0]    IFID_rs,
    input  logic [4:0]    IFID_rt,
    input  logic [4:0]    IDEX_rt,
    input  logic          IDEX_memRead,
    input  logic          EXMEM_iord,
    input  logic          branch,
    input  logic          br_resolvido,
    input  logic          br_tomado,
    input  logic          LimpaConta,
    output logic          PCEscreve,
    output logic          IFIDEscreve,
    output logic          HazMuxControle,
    output logic          IFIDFlush,
    output logic          MemSel,
    output logic          ErroBranch,
    output logic [CW-1:0] ContaBolhas
);

    localparam int TW = (BR_TIMEOUT > 1) ? $clog2(BR_TIMEOUT) : 1;

    haz_state_t    state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          erro_q, erro_d;
    logic [CW-1:0] conta_q, conta_d;

    logic lu;
    logic mc;
    logic stall;
    logic pc_we, ifid_we, haz_mux, flush;

    detecta_loaduse u_detecta_loaduse (
        .IFID_rs      (IFID_rs),
        .IFID_rt      (IFID_rt),
        .IDEX_rt      (IDEX_rt),
        .IDEX_memRead (IDEX_memRead),
        .lu           (lu)
    );

    assign mc = EXMEM_iord;

    // Next state, timer and stall decode.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        erro_d  = erro_q;
        stall   = 1'b0;
        pc_we   = 1'b1;
        ifid_we = 1'b1;
        haz_mux = 1'b0;
        flush   = 1'b0;

        unique case (state_q)
            HAZ_RUN: begin
                stall = lu | mc | branch;
                // A branch blocked by lu/mc simply retries next cycle.
                if (branch && !lu && !mc) begin
                    state_d = HAZ_BR_WAIT;
                    timer_d = TW'(BR_TIMEOUT - 1);
                end
            end
            HAZ_BR_WAIT: begin
                stall = 1'b1;
                if (br_resolvido && br_tomado) begin
                    state_d = HAZ_FLUSH;
                end else if (br_resolvido) begin
                    state_d = HAZ_RUN;
                end else if (timer_q == '0) begin
                    state_d = HAZ_RUN;
                    erro_d  = 1'b1;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            HAZ_FLUSH: begin
                // Front end still frozen if data owns the port, but IF/ID is flushed.
                flush   = 1'b1;
                state_d = HAZ_RUN;
            end
            default: begin
                state_d = HAZ_RUN;
            end
        endcase

        if (stall) begin
            pc_we   = 1'b0;
            ifid_we = 1'b0;
            haz_mux = 1'b1;
        end else if (state_q == HAZ_FLUSH && mc) begin
            pc_we   = 1'b0;
            ifid_we = 1'b0;
        end
    end

    // Bubble counter: clear beats increment, holds at all-ones.
    always_comb begin
        conta_d = conta_q;
        if (LimpaConta) begin
            conta_d = '0;
        end else if (haz_mux && (conta_q != '1)) begin
            conta_d = conta_q + CW'(1);
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q <= HAZ_RUN;
            timer_q <= '0;
            erro_q  <= 1'b0;
            conta_q <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            erro_q  <= erro_d;
            conta_q <= conta_d;
        end
    end

    // Outputs are forced to a safe frozen-front-end value while Reset is low.
    assign PCEscreve      = Reset & pc_we;
    assign IFIDEscreve    = Reset & ifid_we;
    assign HazMuxControle = ~Reset | haz_mux;
    assign IFIDFlush      = Reset & flush;
    assign MemSel         = Reset & mc;
    assign ErroBranch     = erro_q;
    assign ContaBolhas    = conta_q;

endmodule : controle_hazard_seq

// File: doc/controle_hazard_seq.md
# controle_hazard_seq

Sequential hazard and stall controller for the 5-stage MIPS pipeline. It sits beside ID and drives PC/IF/ID write enables and the ID/EX bubble mux. It detects load-use hazards, holds the front end across multi-cycle branch resolution and flushes IF/ID on taken branches. It also arbitrates the single unified memory port between instruction fetch and MEM-stage data access, and keeps a saturating bubble counter for performance monitoring.

## Interface
- BR_TIMEOUT, 8: max cycles spent in BR_WAIT before forced release.
- CW, 16: width of the bubble counter.

Ports:
- Clock  in  1  system clock; all state updates on the rising edge.
- Reset  in  1  asynchronous, active-low reset.
- IFID_rs  in  5  rs field of the instruction in ID.
- IFID_rt  in  5  rt field of the instruction in ID.
- IDEX_rt  in  5  destination rt of the instruction in EX.
- IDEX_memRead  in  1  EX instruction is a load.
- EXMEM_iord  in  1  MEM stage claims the memory port this cycle.
- branch  in  1  branch instruction present in ID.
- br_resolvido  in  1  branch outcome valid (EX/MEM), one-cycle pulse.
- br_tomado  in  1  branch taken; qualified by br_resolvido.
- LimpaConta  in  1  synchronous clear of ContaBolhas.
- PCEscreve  out  1  PC write enable.
- IFIDEscreve  out  1  IF/ID register write enable.
- HazMuxControle  out  1  1 = zero control signals into ID/EX (bubble).
- IFIDFlush  out  1  clear IF/ID contents.
- MemSel  out  1  memory port owner: 0 = fetch, 1 = data.
- ErroBranch  out  1  sticky; set on BR_WAIT timeout.
- ContaBolhas  out  CW  number of bubble cycles, saturating.

## Operation
- lu = IDEX_memRead & (IDEX_rt != 0) & (IDEX_rt == IFID_rs | IDEX_rt == IFID_rt).
- mc = EXMEM_iord. MemSel = EXMEM_iord in every state (data wins the port).
- stall = 1 means PCEscreve=0, IFIDEscreve=0, HazMuxControle=1. No stall means 1, 1, 0.
- States are RUN, BR_WAIT and FLUSH.
- RUN:
  - stall = lu | mc | branch.
  - Go to BR_WAIT only when branch & !lu & !mc, and load the timer with BR_TIMEOUT-1.
  - Otherwise stay in RUN. A branch blocked by lu or mc is re-evaluated the next cycle.
- BR_WAIT:
  - stall = 1.
  - br_resolvido & br_tomado: go to FLUSH.
  - br_resolvido & !br_tomado: go to RUN.
  - If neither and the timer is 0: go to RUN and set ErroBranch.
  - Otherwise the timer decrements.
- FLUSH (one cycle):
  - PCEscreve=1, IFIDEscreve=1, HazMuxControle=0, IFIDFlush=1.
  - Exception: if mc=1, PCEscreve=0 and IFIDEscreve=0, with IFIDFlush still 1.
  - Always go to RUN.
- IFIDFlush is 0 outside FLUSH.
- ContaBolhas:
  - Increments on each edge where HazMuxControle=1.
  - Saturates at 2^CW-1.
  - LimpaConta has priority over the increment.
- ErroBranch is cleared only by Reset.

## Timing
- Stall outputs are combinational from inputs plus state, so a hazard is answered in the same cycle (0 latency).
- State, timer, ErroBranch and ContaBolhas are registered.
- Reset low, regardless of inputs:
  - State = RUN, timer = 0, ErroBranch = 0, ContaBolhas = 0.
  - PCEscreve=0, IFIDEscreve=0, HazMuxControle=1, IFIDFlush=0, MemSel=0.
- Reset asserted mid-BR_WAIT aborts the wait; there is no flush on release.
- Load-use costs exactly 1 bubble cycle. After the edge, IDEX_memRead is no longer the same load.
- Branch costs 1 RUN cycle plus k BR_WAIT cycles, where k is the number of cycles until br_resolvido, plus 1 FLUSH cycle if taken.
- br_resolvido asserted while in RUN is ignored.
- Timeout: at most BR_TIMEOUT cycles in BR_WAIT.

## Structure
- Shared package hazard_pkg holds:
  - the state encoding (HAZ_RUN=2'd0, HAZ_BR_WAIT=2'd1, HAZ_FLUSH=2'd2);
  - REG_ZERO=5'd0;
  - the default BR_TIMEOUT constant.
- One combinational sub-module, detecta_loaduse, computes lu. It is reused by the forwarding unit tests.
- The FSM, timer and counter live in controle_hazard_seq.

## Test plan
- Load-use: IFID_rs=IFID_rt=IDEX_rt=20, IDEX_memRead=1, others 0.
  - Expect PCEscreve=0, IFIDEscreve=0, HazMuxControle=1 for one cycle.
  - Expect ContaBolhas +1.
  - With IDEX_rt=0, expect no stall.
- Memory conflict: EXMEM_iord=1 in RUN.
  - Expect MemSel=1 and stall asserted.
  - With branch=1 at the same time, state stays RUN.
  - Release EXMEM_iord: the branch enters BR_WAIT.
- Taken branch: branch=1, then br_resolvido=br_tomado=1 two cycles later.
  - Expect 3 stall cycles, then FLUSH with IFIDFlush=1 and PCEscreve=1.
  - Then RUN, with outputs 1, 1, 0.
- Not-taken branch: same stimulus with br_tomado=0.
  - Expect return to RUN with no IFIDFlush.
- Timeout and reset: BR_TIMEOUT=4 with br_resolvido never asserted.
  - Expect release after 4 BR_WAIT cycles and ErroBranch=1.
  - Assert Reset mid-wait: all outputs reach their reset values immediately, and ErroBranch=0.
- Counter: force stall for 2^CW+3 cycles with CW=4.
  - Expect ContaBolhas=15.
  - Then LimpaConta=1 together with a stall: expect 0.
